// File: rtl/stripe_feeder_pkg.sv
// Shared types and constants for the stripe feeder: FSM states, default
// widths, job descriptor layout and the PE instruction bit positions.
package stripe_feeder_pkg;

  localparam int TAG_W   = 12;
  localparam int BLK_W   = 128;
  localparam int INSTR_W = 7;

  // Instruction bits decoded by the PEs in the stripe.
  localparam int INSTR_ACC_BIT     = 2;
  localparam int INSTR_READOUT_BIT = 4;
  localparam int INSTR_WR_ACC_BIT  = 5;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    FETCH,
    WAIT,
    ISSUE,
    DRAIN,
    DONE
  } feeder_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag_a;
    logic [TAG_W-1:0]   tag_b;
    logic [TAG_W-1:0]   stride_a;
    logic [TAG_W-1:0]   stride_b;
    logic [TAG_W-1:0]   iter_lim;
    logic [INSTR_W-1:0] instr;
  } job_desc_t;

endpackage

// File: rtl/feeder_operand_slot.sv
// Holding register plus got flag for one operand memory port; a strobe
// arriving in the same cycle is forwarded so the pair can issue at once.
module feeder_operand_slot #(
  parameter int block_width = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture_en,
  input  logic                   clear,
  input  logic                   mem_valid,
  input  logic [block_width-1:0] mem_data,
  output logic                   present,
  output logic [block_width-1:0] data
);

  logic                   got_reg;
  logic [block_width-1:0] hold_reg;
  logic                   take;

  // Repeated strobes after the first one are dropped.
  assign take = capture_en & mem_valid & ~got_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      got_reg  <= 1'b0;
      hold_reg <= '0;
    end else if (clear) begin
      got_reg  <= 1'b0;
    end else if (take) begin
      got_reg  <= 1'b1;
      hold_reg <= mem_data;
    end
  end

  assign present = got_reg | take;
  assign data    = got_reg ? hold_reg : mem_data;

endmodule

// File: rtl/stripe_feeder.sv
// Job sequencer for one PE stripe: programs the stripe, streams tagged
// operand pairs from two block memories, then captures the stripe result.
module stripe_feeder
  import stripe_feeder_pkg::*;
#(
  parameter int block_width  = BLK_W,
  parameter int tag_width    = TAG_W,
  parameter int instr_width  = INSTR_W,
  parameter int drain_cycles = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [tag_width-1:0]   job_tag_a,
  input  logic [tag_width-1:0]   job_tag_b,
  input  logic [tag_width-1:0]   job_stride_a,
  input  logic [tag_width-1:0]   job_stride_b,
  input  logic [tag_width-1:0]   job_iter_lim,
  input  logic [instr_width-1:0] job_instr,
  output logic                   mem_a_req,
  output logic                   mem_b_req,
  output logic [tag_width-1:0]   mem_a_addr,
  output logic [tag_width-1:0]   mem_b_addr,
  input  logic                   mem_a_valid,
  input  logic                   mem_b_valid,
  input  logic [block_width-1:0] mem_a_data,
  input  logic [block_width-1:0] mem_b_data,
  output logic                   tag_wr,
  output logic [tag_width-1:0]   tagA_OUT,
  output logic [tag_width-1:0]   tagB_OUT,
  output logic [tag_width-1:0]   strideA_OUT,
  output logic [tag_width-1:0]   strideB_OUT,
  output logic [tag_width-1:0]   iter_lim_OUT,
  output logic [tag_width-1:0]   iter_count_OUT,
  output logic [instr_width-1:0] instr_OUT,
  output logic                   blk_valid,
  output logic [block_width-1:0] d0_OUT,
  output logic [block_width-1:0] d1_OUT,
  input  logic [block_width-1:0] d_IN,
  output logic                   res_valid,
  output logic [block_width-1:0] res_data
);

  localparam logic [3:0]           DRAIN_LAST = 4'(drain_cycles - 1);
  localparam logic [tag_width-1:0] TAG_ONE    = {{(tag_width-1){1'b0}}, 1'b1};

  feeder_state_t          state_reg, state_next;
  logic [tag_width-1:0]   cur_a_reg, cur_a_next, cur_b_reg, cur_b_next;
  logic [tag_width-1:0]   count_reg, count_next;
  logic [tag_width-1:0]   stride_a_reg, stride_a_next, stride_b_reg, stride_b_next;
  logic [tag_width-1:0]   lim_reg, lim_next;
  logic [instr_width-1:0] instr_reg, instr_next;
  logic [3:0]             drain_reg, drain_next;

  logic                   job_ready_reg, tag_wr_reg, mem_req_reg, blk_valid_reg, res_valid_reg;
  logic [tag_width-1:0]   mem_a_addr_reg, mem_b_addr_reg, tag_a_out_reg, tag_b_out_reg;
  logic [block_width-1:0] d0_reg, d1_reg, res_data_reg;

  logic                   slot_a_present, slot_b_present;
  logic [block_width-1:0] slot_a_data, slot_b_data;

  feeder_operand_slot #(.block_width(block_width)) u_slot_a (
    .clk        (clk),
    .rst        (rst),
    .capture_en (state_reg == WAIT),
    .clear      (state_reg == ISSUE),
    .mem_valid  (mem_a_valid),
    .mem_data   (mem_a_data),
    .present    (slot_a_present),
    .data       (slot_a_data)
  );

  feeder_operand_slot #(.block_width(block_width)) u_slot_b (
    .clk        (clk),
    .rst        (rst),
    .capture_en (state_reg == WAIT),
    .clear      (state_reg == ISSUE),
    .mem_valid  (mem_b_valid),
    .mem_data   (mem_b_data),
    .present    (slot_b_present),
    .data       (slot_b_data)
  );

  always_comb begin
    state_next    = state_reg;
    cur_a_next    = cur_a_reg;
    cur_b_next    = cur_b_reg;
    count_next    = count_reg;
    stride_a_next = stride_a_reg;
    stride_b_next = stride_b_reg;
    lim_next      = lim_reg;
    instr_next    = instr_reg;
    drain_next    = drain_reg;
    case (state_reg)
      IDLE: begin
        if (job_valid) begin
          cur_a_next    = job_tag_a;
          cur_b_next    = job_tag_b;
          stride_a_next = job_stride_a;
          stride_b_next = job_stride_b;
          lim_next      = job_iter_lim;
          instr_next    = job_instr;
          count_next    = '0;
          state_next    = CONFIG;
        end
      end
      CONFIG: begin
        drain_next = '0;
        state_next = (lim_reg == '0) ? DRAIN : FETCH;
      end
      FETCH: state_next = WAIT;
      WAIT: begin
        if (slot_a_present && slot_b_present) state_next = ISSUE;
      end
      ISSUE: begin
        cur_a_next = cur_a_reg + stride_a_reg;
        cur_b_next = cur_b_reg + stride_b_reg;
        count_next = count_reg + TAG_ONE;
        drain_next = '0;
        state_next = (count_next == lim_reg) ? DRAIN : FETCH;
      end
      DRAIN: begin
        if (drain_reg == DRAIN_LAST) state_next = DONE;
        else drain_next = drain_reg + 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cur_a_reg      <= '0;
      cur_b_reg      <= '0;
      count_reg      <= '0;
      stride_a_reg   <= '0;
      stride_b_reg   <= '0;
      lim_reg        <= '0;
      instr_reg      <= '0;
      drain_reg      <= '0;
      job_ready_reg  <= 1'b1;
      tag_wr_reg     <= 1'b0;
      mem_req_reg    <= 1'b0;
      blk_valid_reg  <= 1'b0;
      res_valid_reg  <= 1'b0;
      mem_a_addr_reg <= '0;
      mem_b_addr_reg <= '0;
      tag_a_out_reg  <= '0;
      tag_b_out_reg  <= '0;
      d0_reg         <= '0;
      d1_reg         <= '0;
      res_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cur_a_reg     <= cur_a_next;
      cur_b_reg     <= cur_b_next;
      count_reg     <= count_next;
      stride_a_reg  <= stride_a_next;
      stride_b_reg  <= stride_b_next;
      lim_reg       <= lim_next;
      instr_reg     <= instr_next;
      drain_reg     <= drain_next;
      job_ready_reg <= (state_next == IDLE);
      tag_wr_reg    <= (state_next == CONFIG);
      mem_req_reg   <= (state_next == FETCH);
      blk_valid_reg <= (state_next == ISSUE);
      res_valid_reg <= (state_next == DONE);
      if (state_next == FETCH) begin
        mem_a_addr_reg <= cur_a_next;
        mem_b_addr_reg <= cur_b_next;
      end
      if (state_next == CONFIG || state_next == ISSUE) begin
        tag_a_out_reg <= cur_a_next;
        tag_b_out_reg <= cur_b_next;
      end
      if (state_next == ISSUE) begin
        d0_reg <= slot_a_data;
        d1_reg <= slot_b_data;
      end
      if (state_next == DONE) res_data_reg <= d_IN;
    end
  end

  assign job_ready      = job_ready_reg;
  assign tag_wr         = tag_wr_reg;
  assign mem_a_req      = mem_req_reg;
  assign mem_b_req      = mem_req_reg;
  assign mem_a_addr     = mem_a_addr_reg;
  assign mem_b_addr     = mem_b_addr_reg;
  assign tagA_OUT       = tag_a_out_reg;
  assign tagB_OUT       = tag_b_out_reg;
  assign strideA_OUT    = stride_a_reg;
  assign strideB_OUT    = stride_b_reg;
  assign iter_lim_OUT   = lim_reg;
  assign iter_count_OUT = '0;
  assign instr_OUT      = instr_reg;
  assign blk_valid      = blk_valid_reg;
  assign d0_OUT         = d0_reg;
  assign d1_OUT         = d1_reg;
  assign res_valid      = res_valid_reg;
  assign res_data       = res_data_reg;

endmodule

// File: tb/tb_stripe_feeder.sv
// Scoreboard bench for stripe_feeder: a job-level model predicts config
// writes, memory addresses, issued operand pairs and result captures.
module tb_stripe_feeder;

  localparam int BW    = 128;
  localparam int TW    = 12;
  localparam int IW    = 7;
  localparam int DRAIN = 4;

  logic          clk, rst;
  logic          job_valid, job_ready;
  logic [TW-1:0] job_tag_a, job_tag_b, job_stride_a, job_stride_b, job_iter_lim;
  logic [IW-1:0] job_instr;
  logic          mem_a_req, mem_b_req;
  logic [TW-1:0] mem_a_addr, mem_b_addr;
  logic          mem_a_valid, mem_b_valid;
  logic [BW-1:0] mem_a_data, mem_b_data;
  logic          tag_wr;
  logic [TW-1:0] tagA_OUT, tagB_OUT, strideA_OUT, strideB_OUT, iter_lim_OUT, iter_count_OUT;
  logic [IW-1:0] instr_OUT;
  logic          blk_valid, res_valid;
  logic [BW-1:0] d0_OUT, d1_OUT, d_IN, res_data;

  stripe_feeder #(
    .block_width(BW), .tag_width(TW), .instr_width(IW), .drain_cycles(DRAIN)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_tag_a(job_tag_a), .job_tag_b(job_tag_b),
    .job_stride_a(job_stride_a), .job_stride_b(job_stride_b),
    .job_iter_lim(job_iter_lim), .job_instr(job_instr),
    .mem_a_req(mem_a_req), .mem_b_req(mem_b_req),
    .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
    .mem_a_valid(mem_a_valid), .mem_b_valid(mem_b_valid),
    .mem_a_data(mem_a_data), .mem_b_data(mem_b_data),
    .tag_wr(tag_wr), .tagA_OUT(tagA_OUT), .tagB_OUT(tagB_OUT),
    .strideA_OUT(strideA_OUT), .strideB_OUT(strideB_OUT),
    .iter_lim_OUT(iter_lim_OUT), .iter_count_OUT(iter_count_OUT),
    .instr_OUT(instr_OUT), .blk_valid(blk_valid),
    .d0_OUT(d0_OUT), .d1_OUT(d1_OUT), .d_IN(d_IN),
    .res_valid(res_valid), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [TW-1:0] ta, tb, sa, sb, lim; logic [IW-1:0] instr; } cfg_t;
  typedef struct { logic [TW-1:0] ta, tb; logic [BW-1:0] da, db; int gap; } blk_t;
  typedef struct { logic [TW-1:0] addr; int lat; logic [BW-1:0] data; } plan_t;
  typedef struct { logic [BW-1:0] data; int gap; } res_t;
  typedef struct { int cyc; logic [BW-1:0] data; } pend_t;

  cfg_t  exp_cfg[$];
  blk_t  exp_blk[$];
  res_t  exp_res[$];
  plan_t plan_a[$], plan_b[$];
  pend_t pend_a[$], pend_b[$];

  int tests = 0, fails = 0;
  int cyc = 0, accept_cyc = 0, last_mark = 0, last_res_cyc = 0;
  int n_blk = 0, n_res = 0;
  int lat_a[16], lat_b[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    tests++;
    fails++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic logic [BW-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Job-level model: tag i is base + i*stride modulo 2^TW; period is max latency + 2.
  task automatic plan_job(input logic [TW-1:0] ta, tb, sa, sb, lim,
                          input logic [IW-1:0] ins, input logic [BW-1:0] din);
    cfg_t c;
    blk_t b;
    plan_t p;
    res_t r;
    c.ta = ta; c.tb = tb; c.sa = sa; c.sb = sb; c.lim = lim; c.instr = ins;
    exp_cfg.push_back(c);
    for (int i = 0; i < int'(lim); i++) begin
      b.ta  = TW'((int'(ta) + i * int'(sa)) % (1 << TW));
      b.tb  = TW'((int'(tb) + i * int'(sb)) % (1 << TW));
      b.da  = rand_blk();
      b.db  = rand_blk();
      b.gap = ((lat_a[i] > lat_b[i]) ? lat_a[i] : lat_b[i]) + 2;
      exp_blk.push_back(b);
      p.addr = b.ta; p.lat = lat_a[i]; p.data = b.da; plan_a.push_back(p);
      p.addr = b.tb; p.lat = lat_b[i]; p.data = b.db; plan_b.push_back(p);
    end
    r.data = din;
    r.gap  = DRAIN + 1;
    exp_res.push_back(r);
  endtask

  task automatic drive_desc(input logic [TW-1:0] ta, tb, sa, sb, lim, input logic [IW-1:0] ins);
    job_tag_a = ta; job_tag_b = tb; job_stride_a = sa; job_stride_b = sb;
    job_iter_lim = lim; job_instr = ins; job_valid = 1'b1;
  endtask

  task automatic wait_accept(input string nm);
    int n = 0;
    while (!job_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (!job_ready) begin
      fails++;
      $display("FAIL %s accept: job_ready=0 required 1 within %0d cycles", nm, n);
    end
    accept_cyc = cyc;
  endtask

  task automatic wait_res(input int target, input string nm);
    int n = 0;
    while (n_res < target && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n_res < target) begin
      fails++;
      $display("FAIL %s done: res count %0d required %0d", nm, n_res, target);
    end
  endtask

  task automatic run_job(input string nm, input logic [TW-1:0] ta, tb, sa, sb, lim,
                         input logic [IW-1:0] ins);
    int n0;
    logic [BW-1:0] din;
    n0  = n_res;
    din = rand_blk();
    plan_job(ta, tb, sa, sb, lim, ins, din);
    d_IN = din;
    drive_desc(ta, tb, sa, sb, lim, ins);
    wait_accept(nm);
    @(posedge clk); #1;
    job_valid = 1'b0;
    wait_res(n0 + 1, nm);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_job_ready"}, job_ready, 1);
    check({nm, "_tag_wr"}, tag_wr, 0);
    check({nm, "_mem_req"}, {mem_a_req, mem_b_req}, 0);
    check({nm, "_mem_addr"}, {mem_a_addr, mem_b_addr}, 0);
    check({nm, "_tags"}, {tagA_OUT, tagB_OUT}, 0);
    check({nm, "_cfg"}, {strideA_OUT, strideB_OUT, iter_lim_OUT, iter_count_OUT, instr_OUT}, 0);
    check({nm, "_blk_valid"}, blk_valid, 0);
    check({nm, "_d0"}, d0_OUT, 0);
    check({nm, "_d1"}, d1_OUT, 0);
    check({nm, "_res_valid"}, res_valid, 0);
    check({nm, "_res_data"}, res_data, 0);
  endtask

  // Memory responder: each request is answered after the planned latency.
  initial begin
    plan_t p;
    pend_t q;
    mem_a_valid = 1'b0; mem_b_valid = 1'b0;
    mem_a_data = '0; mem_b_data = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_a_req) begin
        if (plan_a.size() == 0) fail_evt("unexpected_mem_a_req");
        else begin
          p = plan_a.pop_front();
          check("mem_a_addr", mem_a_addr, p.addr);
          q.cyc = cyc + p.lat; q.data = p.data; pend_a.push_back(q);
          $display("[TB] mem_a req addr=%03h lat=%0d", mem_a_addr, p.lat);
        end
      end
      if (mem_b_req) begin
        if (plan_b.size() == 0) fail_evt("unexpected_mem_b_req");
        else begin
          p = plan_b.pop_front();
          check("mem_b_addr", mem_b_addr, p.addr);
          q.cyc = cyc + p.lat; q.data = p.data; pend_b.push_back(q);
          $display("[TB] mem_b req addr=%03h lat=%0d", mem_b_addr, p.lat);
        end
      end
      mem_a_valid = 1'b0; mem_a_data = '0;
      for (int i = 0; i < pend_a.size(); i++) begin
        if (pend_a[i].cyc == cyc) begin
          mem_a_valid = 1'b1; mem_a_data = pend_a[i].data; pend_a.delete(i);
          break;
        end
      end
      mem_b_valid = 1'b0; mem_b_data = '0;
      for (int i = 0; i < pend_b.size(); i++) begin
        if (pend_b[i].cyc == cyc) begin
          mem_b_valid = 1'b1; mem_b_data = pend_b[i].data; pend_b.delete(i);
          break;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction.
  initial begin
    cfg_t c;
    blk_t b;
    res_t r;
    logic prev_res;
    prev_res = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        prev_res = 1'b0;
        continue;
      end
      if (prev_res) check("job_ready_after_res", job_ready, 1);
      prev_res = res_valid;
      if (tag_wr) begin
        check("tag_wr_no_blk", blk_valid, 0);
        check("tag_wr_cycle", cyc, accept_cyc + 1);
        if (exp_cfg.size() == 0) fail_evt("unexpected_tag_wr");
        else begin
          c = exp_cfg.pop_front();
          check("cfg_tags", {tagA_OUT, tagB_OUT}, {c.ta, c.tb});
          check("cfg_strides", {strideA_OUT, strideB_OUT}, {c.sa, c.sb});
          check("cfg_lim_count", {iter_lim_OUT, iter_count_OUT}, {c.lim, 12'h000});
          check("cfg_instr", instr_OUT, c.instr);
        end
        $display("[TB] cfg tagA=%03h tagB=%03h lim=%0d", tagA_OUT, tagB_OUT, iter_lim_OUT);
        last_mark = cyc;
      end
      if (blk_valid) begin
        if (exp_blk.size() == 0) fail_evt("unexpected_blk_valid");
        else begin
          b = exp_blk.pop_front();
          check("blk_tags", {tagA_OUT, tagB_OUT}, {b.ta, b.tb});
          check("blk_d0", d0_OUT, b.da);
          check("blk_d1", d1_OUT, b.db);
          check("blk_period", cyc - last_mark, b.gap);
        end
        $display("[TB] blk tagA=%03h tagB=%03h cycle=%0d", tagA_OUT, tagB_OUT, cyc);
        last_mark = cyc;
        n_blk++;
      end
      if (res_valid) begin
        if (exp_res.size() == 0) fail_evt("unexpected_res_valid");
        else begin
          r = exp_res.pop_front();
          check("res_data", res_data, r.data);
          check("res_latency", cyc - last_mark, r.gap);
        end
        $display("[TB] res data=%0h cycle=%0d", res_data, cyc);
        last_res_cyc = cyc;
        n_res++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, nb0;
    logic [BW-1:0] din1, din2;
    rst = 1'b0; job_valid = 1'b0; d_IN = '0;
    job_tag_a = '0; job_tag_b = '0; job_stride_a = '0; job_stride_b = '0;
    job_iter_lim = '0; job_instr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    lat_a[0] = 2; lat_b[0] = 2; lat_a[1] = 2; lat_b[1] = 2; lat_a[2] = 2; lat_b[2] = 2;
    run_job("basic", 12'h010, 12'h200, 12'h001, 12'h004, 12'd3, 7'h14);

    run_job("lim0", 12'h0AB, 12'h0CD, 12'h001, 12'h001, 12'd0, 7'h30);

    lat_a[0] = 1; lat_b[0] = 2; lat_a[1] = 2; lat_b[1] = 1;
    run_job("wrap", 12'hFFE, 12'h7FF, 12'h003, 12'h801, 12'd2, 7'h04);

    lat_a[0] = 6; lat_b[0] = 1; lat_a[1] = 3; lat_b[1] = 3;
    run_job("order", 12'h100, 12'h300, 12'h010, 12'h020, 12'd2, 7'h24);

    // Reset in the middle of WAIT with an A response still outstanding.
    nb0 = n_blk;
    lat_a[0] = 8; lat_b[0] = 2; lat_a[1] = 1; lat_b[1] = 1;
    plan_job(12'h123, 12'h456, 12'h001, 12'h001, 12'd2, 7'h11, rand_blk());
    drive_desc(12'h123, 12'h456, 12'h001, 12'h001, 12'd2, 7'h11);
    wait_accept("rst_job");
    @(posedge clk); #1;
    job_valid = 1'b0;
    while (cyc < accept_cyc + 5) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check_reset_state("mid_wait_reset");
    exp_blk.delete(); exp_res.delete(); plan_a.delete(); plan_b.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("late_resp_no_blk", n_blk, nb0);
    check("late_resp_ready", job_ready, 1);

    lat_a[0] = 1; lat_b[0] = 1;
    run_job("after_reset", 12'h040, 12'h080, 12'h002, 12'h002, 12'd1, 7'h10);

    // job_valid held high across a whole job with a second descriptor queued.
    n0 = n_res;
    din1 = rand_blk();
    din2 = rand_blk();
    lat_a[0] = 2; lat_b[0] = 3;
    plan_job(12'h321, 12'h654, 12'h005, 12'h006, 12'd1, 7'h01, din1);
    lat_a[0] = 1; lat_b[0] = 4; lat_a[1] = 3; lat_b[1] = 2;
    plan_job(12'h777, 12'h888, 12'h00A, 12'h00B, 12'd2, 7'h22, din2);
    d_IN = din1;
    drive_desc(12'h321, 12'h654, 12'h005, 12'h006, 12'd1, 7'h01);
    wait_accept("held_1");
    @(posedge clk); #1;
    drive_desc(12'h777, 12'h888, 12'h00A, 12'h00B, 12'd2, 7'h22);
    wait_accept("held_2");
    check("held_accept_cycle", accept_cyc, last_res_cyc + 1);
    d_IN = din2;
    @(posedge clk); #1;
    job_valid = 1'b0;
    wait_res(n0 + 2, "held");

    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < 16; i++) begin
        lat_a[i] = $urandom_range(1, 6);
        lat_b[i] = $urandom_range(1, 6);
      end
      run_job("random", TW'($urandom), TW'($urandom), TW'($urandom), TW'($urandom),
              TW'($urandom_range(0, 4)), IW'($urandom));
    end

    repeat (5) @(posedge clk);
    #1;
    check("left_blk", exp_blk.size(), 0);
    check("left_res", exp_res.size(), 0);
    check("left_cfg", exp_cfg.size(), 0);
    check("left_plan", plan_a.size() + plan_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
